// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD pattern sequencer: sequencer states,
// pattern index width and the fixed pattern numbering used by the pixel
// generator, plus the pattern-wrap helper.
package lcd_seq_pkg;

    // Sequencer operating states
    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } seq_state_e;

    // Width of the pattern_sel bus (supports up to 16 patterns)
    localparam int PATTERN_W = 4;

    // Pattern numbering understood by the pixel generator
    localparam logic [PATTERN_W-1:0] COLOR_BAR   = 4'd0;
    localparam logic [PATTERN_W-1:0] GRID        = 4'd1;
    localparam logic [PATTERN_W-1:0] SOLID_WHITE = 4'd2;
    localparam logic [PATTERN_W-1:0] GRADIENT    = 4'd3;

    // Next pattern index, wrapping from num-1 back to 0
    function automatic logic [PATTERN_W-1:0] next_pattern(
        input logic [PATTERN_W-1:0] cur,
        input int                   num
    );
        logic [PATTERN_W-1:0] last_idx;
        last_idx = PATTERN_W'(num - 1);
        if (cur == last_idx) begin
            return {PATTERN_W{1'b0}};
        end else begin
            return cur + 4'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_pattern_sequencer_btn.sv
// Push-button conditioner: 2-FF synchronizer followed by a stability
// counter. Emits a single-cycle press pulse when a debounced release->press
// (1->0) transition is accepted. Releases are debounced but not reported.
// Generic enough to condition the board reset button as well.
module lcd_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic btn_n,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_r;
    logic             sync2_r;
    logic             last_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;
    logic             accept_s;

    // Level has now been stable long enough and differs from the accepted level
    assign accept_s = (sync2_r == last_r) && (cnt_r == CNT_LAST) && (last_r != stable_r);

    // Synchronizer, stability counter and accepted-level tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            last_r   <= 1'b1;
            stable_r <= 1'b1;
            cnt_r    <= CNT_ZERO;
            press_r  <= 1'b0;
        end else if (srst) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            last_r   <= 1'b1;
            stable_r <= 1'b1;
            cnt_r    <= CNT_ZERO;
            press_r  <= 1'b0;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
            if (sync2_r != last_r) begin
                last_r <= sync2_r;
                cnt_r  <= CNT_ZERO;
            end else if (cnt_r < CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if (accept_s) begin
                stable_r <= last_r;
            end else begin
                stable_r <= stable_r;
            end
            press_r <= accept_s && !last_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/lcd_pattern_sequencer.sv
// LCD pattern sequencer: holds the panel dark for a warm-up period, then
// steps through test patterns automatically every FRAMES_PER_PATTERN frames
// and/or on a debounced button press. Pattern changes land only on frame
// start cycles so no frame is torn.
// Optional build macro LCD_SEQ_BL_FADE_EN: backlight becomes an 8-bit PWM
// that fades in after warm-up; otherwise backlight mirrors lcd_en.
module lcd_pattern_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int NUM_PATTERNS       = 4,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int WARMUP_FRAMES      = 4,
    parameter int DEBOUNCE_CYCLES    = 65536,
    parameter int VSYNC_ACTIVE_LOW   = 1
) (
    input  logic                 PixelClk,
    input  logic                 nRST,
    input  logic                 vsync_in,
    input  logic                 next_btn_n,
    input  logic                 auto_en,
    output logic                 lcd_en,
    output logic [PATTERN_W-1:0] pattern_sel,
    output logic                 frame_start,
    output logic                 backlight
);

    // Frame counter also counts warm-up frames, so size it for both uses
    localparam int FC_W  = $clog2(FRAMES_PER_PATTERN + 1);
    localparam int WU_W  = $clog2(WARMUP_FRAMES + 1);
    localparam int CNT_W = (FC_W > WU_W) ? FC_W : WU_W;

    localparam logic [CNT_W-1:0] FC_TERM  = CNT_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [CNT_W-1:0] WU_TERM  = CNT_W'(WARMUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic VSYNC_ACTIVE = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic VSYNC_IDLE   = ~VSYNC_ACTIVE;

    logic                 vsync_r;
    logic                 vsync_d_r;
    logic                 frame_start_r;
    logic                 fs_s;
    logic                 press_s;

    seq_state_e           state_r;
    seq_state_e           state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [PATTERN_W-1:0] pattern_r;
    logic [PATTERN_W-1:0] pattern_s;
    logic                 pending_r;
    logic                 pending_s;
    logic                 adv_s;
    logic                 lcd_en_r;
    logic                 backlight_r;

    // Button conditioning; no soft-reset source at this level
    lcd_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (PixelClk),
        .rst_n (nRST),
        .srst  (1'b0),
        .btn_n (next_btn_n),
        .press (press_s)
    );

    // Active edge of the once-registered VSYNC marks a frame start
    assign fs_s = (vsync_r == VSYNC_ACTIVE) && (vsync_d_r == VSYNC_IDLE);

    // VSYNC pipeline and registered frame-start pulse
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            vsync_r       <= VSYNC_IDLE;
            vsync_d_r     <= VSYNC_IDLE;
            frame_start_r <= 1'b0;
        end else begin
            vsync_r       <= vsync_in;
            vsync_d_r     <= vsync_r;
            frame_start_r <= fs_s;
        end
    end

    // Next-state logic: warm-up counting, frame counting and pattern advance
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pattern_s = pattern_r;
        pending_s = pending_r;
        adv_s     = 1'b0;
        case (state_r)
            WARMUP: begin
                // Presses while the panel is dark are thrown away
                pending_s = 1'b0;
                if (fs_s) begin
                    if (cnt_r == WU_TERM) begin
                        state_s = RUN;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            RUN: begin
                // Pending is sampled before this cycle's press, so a press
                // landing on a frame start waits for the following frame
                adv_s = fs_s && (pending_r || (auto_en && (cnt_r == FC_TERM)));
                if (adv_s) begin
                    pattern_s = next_pattern(pattern_r, NUM_PATTERNS);
                    cnt_s     = CNT_ZERO;
                    pending_s = press_s;
                end else begin
                    // Saturate at the terminal count while auto advance is off
                    if (fs_s && (cnt_r < FC_TERM)) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                    pending_s = pending_r | press_s;
                end
            end
            default: begin
                state_s   = WARMUP;
                cnt_s     = CNT_ZERO;
                pattern_s = COLOR_BAR;
                pending_s = 1'b0;
            end
        endcase
    end

    // Sequencer state registers; lcd_en follows the next state so it rises
    // in the same cycle as the final warm-up frame start
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_r   <= WARMUP;
            cnt_r     <= CNT_ZERO;
            pattern_r <= COLOR_BAR;
            pending_r <= 1'b0;
            lcd_en_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pattern_r <= pattern_s;
            pending_r <= pending_s;
            lcd_en_r  <= (state_s == RUN);
        end
    end

`ifdef LCD_SEQ_BL_FADE_EN
    logic [7:0] duty_r;
    logic [7:0] pwm_cnt_r;

    // Backlight fade-in: duty steps up once per running frame, PWM period 256
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            duty_r      <= 8'd0;
            pwm_cnt_r   <= 8'd0;
            backlight_r <= 1'b0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
            if ((state_r == RUN) && fs_s && (duty_r != 8'hFF)) begin
                duty_r <= duty_r + 8'd1;
            end else begin
                duty_r <= duty_r;
            end
            backlight_r <= (duty_r == 8'hFF) || (pwm_cnt_r < duty_r);
        end
    end
`else
    // Backlight tracks the panel enable with identical timing
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            backlight_r <= 1'b0;
        end else begin
            backlight_r <= (state_s == RUN);
        end
    end
`endif

    assign lcd_en      = lcd_en_r;
    assign pattern_sel = pattern_r;
    assign frame_start = frame_start_r;
    assign backlight   = backlight_r;

endmodule
